mem_arb_2to1: RTL

- Two-master to one-slave arbiter for the req/gnt/rvalid memory protocol used by the zeroriscy cores.
- Lets core0 and core1 share a single-port memory: instruction or data.
- Round-robin arbitration; tracks outstanding grants so each rvalid/rdata returns to the master that issued the request.
- Sits between the cores' instr_*/data_* ports and the memory.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_id_fifo.sv | 60 ++++++
 rtl/mem_arb_2to1.sv | 117 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the 2:1 memory arbiter.
package mem_arb_pkg;

  typedef logic [0:0] master_id_t;

  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

  // Pointer width for an ID FIFO of the given depth; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of master IDs for granted-but-not-yet-returned transactions.
// A push and a pop in the same cycle are accepted even when the FIFO is full.
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  master_id_t push_id_i,
  input  logic       pop_i,
  output master_id_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PtrW = ptr_w(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] cnt_q;
  master_id_t      mem_q [DEPTH];
  logic            do_push, do_pop;

  // Explicit wrap so depth 1 works with a one-bit pointer.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  // Qualify push/pop against occupancy.
  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
  end

  // Pointer, count and storage update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= M0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop) cnt_q <= cnt_q + CntW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arb_2to1.sv
// Round-robin 2:1 arbiter for the req/gnt/rvalid memory protocol.
// Optional grant/conflict counters are enabled by defining MEM_ARB_PERF_CNT_EN.
module mem_arb_2to1
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_req_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                err_o
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]         m0_gnt_cnt_o,
  output logic [31:0]         m1_gnt_cnt_o,
  output logic [31:0]         conflict_cnt_o
`endif
);

  master_id_t sel;
  master_id_t last_q;
  master_id_t fifo_head;
  logic       fifo_full, fifo_empty;
  logic       handshake;
  logic       err_q;

  // Select a requester; on contention the one not granted last wins.
  always_comb begin
    sel = M0;
    if (m0_req_i && m1_req_i) sel = ~last_q;
    else if (m1_req_i)        sel = M1;
  end

  // Forward the selected request and route grants/responses.
  always_comb begin
    mem_req_o   = (m0_req_i | m1_req_i) & ~fifo_full;
    handshake   = mem_req_o & mem_gnt_i;
    m0_gnt_o    = handshake & (sel == M0);
    m1_gnt_o    = handshake & (sel == M1);
    mem_addr_o  = (sel == M1) ? m1_addr_i  : m0_addr_i;
    mem_we_o    = (sel == M1) ? m1_we_i    : m0_we_i;
    mem_be_o    = (sel == M1) ? m1_be_i    : m0_be_i;
    mem_wdata_o = (sel == M1) ? m1_wdata_i : m0_wdata_i;
    // A response with nothing outstanding is dropped and only flags an error.
    m0_rvalid_o = mem_rvalid_i & ~fifo_empty & (fifo_head == M0);
    m1_rvalid_o = mem_rvalid_i & ~fifo_empty & (fifo_head == M1);
  end

  assign m0_rdata_o = mem_rdata_i;
  assign m1_rdata_o = mem_rdata_i;
  assign err_o      = err_q;

  // Last-grant pointer and sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= M1;
      err_q  <= 1'b0;
    end else begin
      if (handshake) last_q <= sel;
      if (mem_rvalid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  mem_arb_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (handshake),
    .push_id_i (sel),
    .pop_i     (mem_rvalid_i),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

`ifdef MEM_ARB_PERF_CNT_EN
  // Per-master handshake counts and contention cycles (both requesting).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m0_gnt_cnt_o   <= '0;
      m1_gnt_cnt_o   <= '0;
      conflict_cnt_o <= '0;
    end else begin
      if (m0_gnt_o)              m0_gnt_cnt_o   <= m0_gnt_cnt_o + 32'd1;
      if (m1_gnt_o)              m1_gnt_cnt_o   <= m1_gnt_cnt_o + 32'd1;
      if (m0_req_i && m1_req_i)  conflict_cnt_o <= conflict_cnt_o + 32'd1;
    end
  end
`endif

endmodule
